// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - pipeline valid/PC control with branch redirect, hold bubbles, flush and perf counters
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   hold                       load-use stall request (freezes stages 0..HOLD_STAGE)
//   br_taken, br_target        taken branch resolved in BR_STAGE and its redirect address
//   flush_all, flush_target    global flush and the address to fetch afterwards
//   cnt_clr                    synchronous clear of both performance counters
//   fetch_pc                   next fetch address
//   stg_vld, stg_pc            per-stage valid bits and PCs (stage i at bit i / slice i)
//   retire, retire_pc          valid bit and PC of the oldest stage
//   retire_cnt, bubble_cnt     saturating retire and hold-bubble counters
module pipe_stage_ctrl #(
    parameter int              XLEN       = 32,
    parameter int              STAGES     = 5,
    parameter int              BR_STAGE   = 2,
    parameter int              HOLD_STAGE = 1,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hold,
    input  logic                     br_taken,
    input  logic [XLEN-1:0]          br_target,
    input  logic                     flush_all,
    input  logic [XLEN-1:0]          flush_target,
    input  logic                     cnt_clr,
    output logic [XLEN-1:0]          fetch_pc,
    output logic [STAGES-1:0]        stg_vld,
    output logic [STAGES*XLEN-1:0]   stg_pc,
    output logic                     retire,
    output logic [XLEN-1:0]          retire_pc,
    output logic [31:0]              retire_cnt,
    output logic [31:0]              bubble_cnt
);

    logic [XLEN-1:0]              r_pc;
    logic [STAGES-1:0]            r_vld;
    logic [STAGES-1:0][XLEN-1:0]  r_stg_pc;
    logic [31:0]                  r_retire_cnt;
    logic [31:0]                  r_bubble_cnt;

    logic [XLEN-1:0]              w_pc_nxt;
    logic [STAGES-1:0]            w_vld_nxt;
    logic [STAGES-1:0][XLEN-1:0]  w_stg_pc_nxt;
    logic                         w_act_br;
    logic                         w_act_hold;

    // Only the highest-priority event acts: flush > branch > hold > advance.
    assign w_act_br   = !flush_all && br_taken;
    assign w_act_hold = !flush_all && !br_taken && hold;

    always_comb begin
        // Default is a normal advance; events below override pieces of it.
        w_pc_nxt     = r_pc + XLEN'(1);
        w_vld_nxt    = {r_vld[STAGES-2:0], 1'b1};
        w_stg_pc_nxt = {r_stg_pc[STAGES-2:0], r_pc};
        if (flush_all) begin
            w_pc_nxt     = flush_target;
            w_vld_nxt    = '0;
            w_stg_pc_nxt = r_stg_pc;
        end else if (w_act_br) begin
            // The branch itself moves on to BR_STAGE+1 with its own valid bit;
            // everything younger is wrong-path and gets squashed.
            w_pc_nxt = br_target;
            for (int i = 0; i <= BR_STAGE; i++) begin
                w_vld_nxt[i] = 1'b0;
            end
        end else if (w_act_hold) begin
            w_pc_nxt = r_pc;
            for (int i = 0; i <= HOLD_STAGE; i++) begin
                w_vld_nxt[i]    = r_vld[i];
                w_stg_pc_nxt[i] = r_stg_pc[i];
            end
            // Bubble carries the held stage's PC so downstream PCs stay meaningful.
            w_vld_nxt[HOLD_STAGE+1]    = 1'b0;
            w_stg_pc_nxt[HOLD_STAGE+1] = r_stg_pc[HOLD_STAGE];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_vld        <= '0;
            r_stg_pc     <= {STAGES{RESET_PC}};
            r_retire_cnt <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_pc     <= w_pc_nxt;
            r_vld    <= w_vld_nxt;
            r_stg_pc <= w_stg_pc_nxt;
            if (cnt_clr) begin
                r_retire_cnt <= '0;
                r_bubble_cnt <= '0;
            end else begin
                if (r_vld[STAGES-1] && (r_retire_cnt != 32'hFFFF_FFFF)) begin
                    r_retire_cnt <= r_retire_cnt + 32'd1;
                end
                if (w_act_hold && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
                    r_bubble_cnt <= r_bubble_cnt + 32'd1;
                end
            end
        end
    end

    assign fetch_pc   = r_pc;
    assign stg_vld    = r_vld;
    assign stg_pc     = r_stg_pc;
    assign retire     = r_vld[STAGES-1];
    assign retire_pc  = r_stg_pc[STAGES-1];
    assign retire_cnt = r_retire_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: doc/pipe_stage_ctrl.md
PIPE_STAGE_CTRL -- requirements
Module: pipe_stage_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC width in bits.
REQ-002 SHALL have parameter STAGES, default 5, legal range 3..16: pipeline depth; stage 0 is the youngest stage and stage STAGES-1 the oldest.
REQ-003 SHALL have parameter BR_STAGE, default 2, legal range 1..STAGES-2: the stage that resolves branches.
REQ-004 SHALL have parameter HOLD_STAGE, default 1, legal range 0..BR_STAGE-1: the oldest stage frozen by a hold.
REQ-005 SHALL have parameter RESET_PC, default 0, width XLEN: fetch address after reset.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 hold  input  1  load-use stall request.
REQ-009 br_taken  input  1  branch in BR_STAGE resolved as taken.
REQ-010 br_target  input  XLEN  redirect address.
REQ-011 flush_all  input  1  exception/global flush.
REQ-012 flush_target  input  XLEN  address to fetch after a flush.
REQ-013 cnt_clr  input  1  synchronous clear of both counters.
REQ-014 fetch_pc  output  XLEN  next fetch address (register pc_r).
REQ-015 stg_vld  output  STAGES  per-stage valid bits; bit i belongs to stage i.
REQ-016 stg_pc  output  STAGES*XLEN  per-stage PC; bits [i*XLEN +: XLEN] belong to stage i.
REQ-017 retire, retire_pc  output  1, XLEN  equal to stg_vld[STAGES-1] and the PC of stage STAGES-1.
REQ-018 retire_cnt, bubble_cnt  output  32, 32  performance counters.

Function
REQ-019 Priority SHALL be flush_all > br_taken > hold > normal advance; only the highest-priority active event acts in a cycle.
REQ-020 Normal advance SHALL:
- load stage 0 with {vld=1, pc=pc_r};
- move stage i to stage i+1 for every i;
- set pc_r to pc_r+1 (word-addressed), wrapping modulo 2^XLEN.
REQ-021 A br_taken cycle SHALL:
- set pc_r to br_target;
- move stage BR_STAGE to BR_STAGE+1 with its valid bit unchanged;
- clear the valid bits of stages 0..BR_STAGE;
- shift stages older than BR_STAGE+1 normally.
REQ-022 br_taken SHALL be acted on regardless of stg_vld[BR_STAGE]; qualifying br_taken with valid is the caller's duty.
REQ-023 A hold cycle SHALL:
- keep stages 0..HOLD_STAGE and pc_r unchanged;
- load stage HOLD_STAGE+1 with vld=0 and a pc copied from HOLD_STAGE;
- shift stages older than HOLD_STAGE+1 normally.
REQ-024 Consecutive hold cycles SHALL each insert one bubble; there is no hold length limit.
REQ-025 A flush_all cycle SHALL set pc_r to flush_target and clear every stg_vld bit; stg_pc values are don't-care where vld=0.
REQ-026 retire_cnt SHALL increment by 1 on each edge where retire=1.
REQ-027 bubble_cnt SHALL increment by 1 on each edge where hold is the acting event.
REQ-028 Both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-029 cnt_clr SHALL zero both counters on the next edge and SHALL take priority over increments; it SHALL not affect the pipeline.
REQ-030 All outputs SHALL be registered or direct register copies; no combinational input-to-output path.

Reset
REQ-031 When rst_n=0 at an edge, pc_r SHALL become RESET_PC, stg_vld all 0, stg_pc all RESET_PC, and both counters 0; this overrides every other input, including mid-operation.
REQ-032 On the first edge with rst_n=1, normal rules SHALL apply; stage 0 receives RESET_PC with vld=1 unless hold, br_taken or flush_all is active.

Verification (STAGES=5, BR_STAGE=2, HOLD_STAGE=1, RESET_PC=0, XLEN=32)
REQ-033 Reset, then 5 free-running edges -> stg_vld=5'b11111; stage i pc = 4-i; retire_pc=0; fetch_pc=5; retire_cnt=0; one edge later retire_cnt=1.
REQ-034 br_taken=1, br_target=0x40 while stage2 pc=3 -> next edge: stg_vld[2:0]=0, stage3 pc=3 valid, fetch_pc=0x40; following edge: stage0 pc=0x40 valid.
REQ-035 hold for 2 cycles while stage1 pc=5, stage0 pc=6 -> stages 0/1 stay 6/5 and fetch_pc stays 7; stage2 shows vld=0 on both edges; bubble_cnt +2.
REQ-036 hold=1 and br_taken=1 in the same cycle -> redirect behaviour per REQ-021; bubble_cnt unchanged.
REQ-037 flush_all=1, flush_target=0x100 with a full pipe -> stg_vld=0 and fetch_pc=0x100; retire stays 0 for the next 4 edges and is 1 on the 5th, with retire_pc=0x100.
REQ-038 Force pc_r to 0xFFFF_FFFF via flush_target and advance -> fetch_pc wraps to 0; rst_n=0 mid-stream -> full reset state on that edge.
